// File: rtl/uart_baud_tx.sv
// uart_baud_tx: UART transmitter. It contains a free-running oversample and baud
// tick generator and an 8N1-style serializer that sends data LSB-first.
// The serial line, busy and done outputs all come from registers.
// The divclk and baudclk strobes are decoded from the divider counters.

module uart_baud_tx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 sysclk_in,
  input  logic                 rst_in,
  input  logic                 data_rdy_in,
  input  logic [DATA_BITS-1:0] tx_data_in,
  output logic                 tx_serial_out,
  output logic                 tx_busy_out,
  output logic                 tx_done_out,
  output logic                 divclk_out,
  output logic                 baudclk_out
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLING);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_baud_tx: CLK_FREQ too low for BAUD_RATE*OVERSAMPLING");
    end
    if (OVERSAMPLING < 1) begin : g_bad_os
      $error("uart_baud_tx: OVERSAMPLING must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic                 div_tick;
  logic                 baud_tick;
  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_shift;
  logic [BIT_W-1:0]     bit_cnt;

  assign div_tick    = (div_cnt == DIV_LAST);
  assign baud_tick   = div_tick && (os_cnt == OS_LAST);
  assign shreg_shift = shreg >> 1;

  // Gate the strobes with reset so they stay low while reset is held, even when DIV is 1.
  assign divclk_out  = div_tick & ~rst_in;
  assign baudclk_out = baud_tick & ~rst_in;

  // Oversample divider: this counter wraps every DIV cycles.
  always_ff @(posedge sysclk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt <= '0;
    end else if (div_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Baud divider: this counter counts oversample strobes and wraps once per bit period.
  always_ff @(posedge sysclk_in or posedge rst_in) begin
    if (rst_in) begin
      os_cnt <= '0;
    end else if (div_tick) begin
      if (os_cnt == OS_LAST) begin
        os_cnt <= '0;
      end else begin
        os_cnt <= os_cnt + OS_W'(1);
      end
    end
  end

  // Serializer FSM. The registered line value is updated on the same tick that changes
  // the state, so each line edge appears one cycle after its baud strobe.
  always_ff @(posedge sysclk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      tx_serial_out <= 1'b1;
      tx_busy_out   <= 1'b0;
      tx_done_out   <= 1'b0;
    end else begin
      tx_done_out <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (data_rdy_in) begin
              shreg         <= tx_data_in;
              bit_cnt       <= '0;
              state         <= START;
              tx_serial_out <= 1'b0;
              tx_busy_out   <= 1'b1;
            end
          end
          START: begin
            state         <= DATA;
            tx_serial_out <= shreg[0];
          end
          DATA: begin
            shreg   <= shreg_shift;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              state         <= STOP;
              tx_serial_out <= 1'b1;
            end else begin
              tx_serial_out <= shreg_shift[0];
            end
          end
          STOP: begin
            tx_done_out <= 1'b1;
            if (data_rdy_in) begin
              // Back-to-back frame: the next start bit follows the stop bit with no idle bit between them.
              shreg         <= tx_data_in;
              bit_cnt       <= '0;
              state         <= START;
              tx_serial_out <= 1'b0;
            end else begin
              state         <= IDLE;
              tx_busy_out   <= 1'b0;
              tx_serial_out <= 1'b1;
            end
          end
          default: begin
            state         <= IDLE;
            tx_busy_out   <= 1'b0;
            tx_serial_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_tx.sv
// tb_uart_baud_tx: random-data bench for uart_baud_tx. A short bit period keeps the run small.
// Expected line, busy and done traces come from frame/bit arithmetic on the words sent.

module tb_uart_baud_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 31_250;
  localparam int OS       = 8;
  localparam int DB       = 8;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int BIT      = DIV * OS;
  localparam int FRAME    = (DB + 2) * BIT;
  localparam int MAXW     = 16;
  localparam int LOG      = MAXW * FRAME + BIT;

  logic          sysclk_in = 1'b0;
  logic          rst_in;
  logic          data_rdy_in;
  logic [DB-1:0] tx_data_in;
  logic          tx_serial_out;
  logic          tx_busy_out;
  logic          tx_done_out;
  logic          divclk_out;
  logic          baudclk_out;

  int checks = 0;
  int errors = 0;

  logic          line_log [LOG];
  logic          busy_log [LOG];
  logic          done_log [LOG];
  logic [DB-1:0] wq [MAXW];
  bit            cap_timeout;

  uart_baud_tx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD),
    .OVERSAMPLING(OS),
    .DATA_BITS   (DB)
  ) dut (
    .sysclk_in    (sysclk_in),
    .rst_in       (rst_in),
    .data_rdy_in  (data_rdy_in),
    .tx_data_in   (tx_data_in),
    .tx_serial_out(tx_serial_out),
    .tx_busy_out  (tx_busy_out),
    .tx_done_out  (tx_done_out),
    .divclk_out   (divclk_out),
    .baudclk_out  (baudclk_out)
  );

  // Clock generator.
  always #5 sysclk_in = ~sysclk_in;

  // Watchdog timer.
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference model. t counts cycles from the first start-bit cycle, and n is the number of frames sent.
  function automatic logic exp_line(input int t, input int n);
    int f;
    int b;
    if (t >= n * FRAME) return 1'b1;
    f = t / FRAME;
    b = (t % FRAME) / BIT;
    if (b == 0) return 1'b0;
    if (b == DB + 1) return 1'b1;
    return wq[f][b-1];
  endfunction

  function automatic logic exp_busy(input int t, input int n);
    return (t < n * FRAME);
  endfunction

  function automatic logic exp_done(input int t, input int n);
    return (t > 0) && (t <= n * FRAME) && (t % FRAME == 0);
  endfunction

  // Bit-centre receiver working on the captured line trace.
  function automatic logic [DB-1:0] rx_word(input int f);
    logic [DB-1:0] w;
    for (int b = 0; b < DB; b++) w[b] = line_log[f*FRAME + (b+1)*BIT + BIT/2];
    return w;
  endfunction

  // Sends wq[0..n-1] and logs outputs starting from the first start-bit cycle.
  // In pulse mode, rdy is high for one bit period. Otherwise rdy stays high until the last
  // frame starts. Each word is replaced by the next one right after its start bit falls.
  task automatic drive_and_capture(input int n, input bit pulse);
    int c;
    int f;
    cap_timeout = 1'b0;
    @(negedge sysclk_in);
    tx_data_in  = wq[0];
    data_rdy_in = 1'b1;
    c = 0;
    do begin
      @(negedge sysclk_in);
      c++;
      if (tx_serial_out !== 1'b0 && c > BIT + 2) begin
        cap_timeout = 1'b1;
        data_rdy_in = 1'b0;
        return;
      end
    end while (tx_serial_out !== 1'b0);
    for (int t = 0; t < n * FRAME + BIT; t++) begin
      if (t > 0) begin
        @(negedge sysclk_in);
        c++;
      end
      line_log[t] = tx_serial_out;
      busy_log[t] = tx_busy_out;
      done_log[t] = tx_done_out;
      if (pulse && c == BIT) data_rdy_in = 1'b0;
      if (t % FRAME == 1) begin
        f = t / FRAME;
        if (f + 1 < n) tx_data_in = wq[f+1];
        else tx_data_in = DB'($urandom);
        if (f == n - 1 && !pulse) data_rdy_in = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int k;
    int div1;
    int div2;
    int baud1;
    int baud2;
    int coinc_bad;
    @(negedge sysclk_in);
    rst_in = 1'b0;
    tx_data_in  = DB'($urandom);
    data_rdy_in = 1'b1;
    repeat (BIT + $urandom_range(0, FRAME - BIT)) @(negedge sysclk_in);
    rst_in      = 1'b1;
    data_rdy_in = 1'b0;
    #1;
    checks++; if (tx_serial_out !== 1'b1) begin errors++; $display("FAIL rst_line: got %b, required 1", tx_serial_out); end
    checks++; if (tx_busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", tx_busy_out); end
    checks++; if (tx_done_out !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", tx_done_out); end
    checks++; if (divclk_out !== 1'b0) begin errors++; $display("FAIL rst_divclk: got %b, required 0", divclk_out); end
    checks++; if (baudclk_out !== 1'b0) begin errors++; $display("FAIL rst_baudclk: got %b, required 0", baudclk_out); end
    repeat (3) @(negedge sysclk_in);
    rst_in = 1'b0;
    // The sample after k rising edges falls in the (k+1)-th clock period after release.
    // The first strobe therefore comes DIV-1 edges after release, which puts it in period DIV.
    div1 = -1; div2 = -1; baud1 = -1; baud2 = -1; coinc_bad = 0;
    k = 0;
    while (baud2 < 0 && k < 3 * BIT) begin
      @(negedge sysclk_in);
      k++;
      if (baudclk_out === 1'b1 && divclk_out !== 1'b1) coinc_bad++;
      if (divclk_out === 1'b1) begin
        if (div1 < 0) div1 = k;
        else if (div2 < 0) div2 = k;
      end
      if (baudclk_out === 1'b1) begin
        if (baud1 < 0) baud1 = k;
        else baud2 = k;
      end
    end
    checks++; if (div1 !== DIV - 1) begin errors++; $display("FAIL first_divclk: at edge %0d, required %0d", div1, DIV - 1); end
    checks++; if (div2 - div1 !== DIV) begin errors++; $display("FAIL divclk_spacing: %0d, required %0d", div2 - div1, DIV); end
    checks++; if (baud1 !== BIT - 1) begin errors++; $display("FAIL first_baudclk: at edge %0d, required %0d", baud1, BIT - 1); end
    checks++; if (baud2 - baud1 !== BIT) begin errors++; $display("FAIL baudclk_spacing: %0d, required %0d", baud2 - baud1, BIT); end
    checks++; if (coinc_bad !== 0) begin errors++; $display("FAIL baud_div_coincide: %0d lone baud strobes, required 0", coinc_bad); end
  endtask

  task automatic test_single_frame();
    int bad;
    int busy_cnt;
    int done_cnt;
    wq[0] = 8'hA5;
    drive_and_capture(1, 1'b1);
    checks++; if (cap_timeout) begin errors++; $display("FAIL single_start: no start bit seen, required within %0d cycles", BIT + 2); end
    bad = 0; busy_cnt = 0; done_cnt = 0;
    for (int t = 0; t < FRAME + BIT; t++) begin
      if (line_log[t] !== exp_line(t, 1)) bad++;
      if (busy_log[t] === 1'b1) busy_cnt++;
      if (done_log[t] === 1'b1) done_cnt++;
      if (done_log[t] !== exp_done(t, 1) || busy_log[t] !== exp_busy(t, 1)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_wave: %0d bad samples, required 0", bad); end
    checks++; if (busy_cnt !== FRAME) begin errors++; $display("FAIL single_busy_len: %0d, required %0d", busy_cnt, FRAME); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_cnt: %0d, required 1", done_cnt); end
    checks++; if (rx_word(0) !== 8'hA5) begin errors++; $display("FAIL single_word: got %h, required a5", rx_word(0)); end
  endtask

  task automatic test_data_change();
    int bad;
    wq[0] = DB'($urandom);
    wq[1] = ~wq[0];
    drive_and_capture(2, 1'b0);
    checks++; if (cap_timeout) begin errors++; $display("FAIL iso_start: no start bit seen, required within %0d cycles", BIT + 2); end
    checks++; if (rx_word(0) !== wq[0]) begin errors++; $display("FAIL iso_word0: got %h, required %h", rx_word(0), wq[0]); end
    checks++; if (rx_word(1) !== wq[1]) begin errors++; $display("FAIL iso_word1: got %h, required %h", rx_word(1), wq[1]); end
    bad = 0;
    for (int t = 0; t < 2 * FRAME + BIT; t++) if (line_log[t] !== exp_line(t, 2)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL iso_wave: %0d bad samples, required 0", bad); end
  endtask

  task automatic test_stream();
    int bad_line;
    int bad_busy;
    int bad_done;
    int done_cnt;
    for (int i = 0; i < MAXW; i++) wq[i] = DB'($urandom);
    drive_and_capture(MAXW, 1'b0);
    checks++; if (cap_timeout) begin errors++; $display("FAIL stream_start: no start bit seen, required within %0d cycles", BIT + 2); end
    for (int i = 0; i < MAXW; i++) begin
      checks++; if (rx_word(i) !== wq[i]) begin errors++; $display("FAIL stream_word%0d: got %h, required %h", i, rx_word(i), wq[i]); end
    end
    bad_line = 0; bad_busy = 0; bad_done = 0; done_cnt = 0;
    for (int t = 0; t < LOG; t++) begin
      if (line_log[t] !== exp_line(t, MAXW)) bad_line++;
      if (busy_log[t] !== exp_busy(t, MAXW)) bad_busy++;
      if (done_log[t] !== exp_done(t, MAXW)) bad_done++;
      if (done_log[t] === 1'b1) done_cnt++;
    end
    checks++; if (bad_line !== 0) begin errors++; $display("FAIL stream_wave: %0d bad samples, required 0", bad_line); end
    checks++; if (bad_busy !== 0) begin errors++; $display("FAIL stream_busy: %0d bad samples, required 0", bad_busy); end
    checks++; if (bad_done !== 0) begin errors++; $display("FAIL stream_done_pos: %0d bad samples, required 0", bad_done); end
    checks++; if (done_cnt !== MAXW) begin errors++; $display("FAIL stream_done_cnt: %0d, required %0d", done_cnt, MAXW); end
  endtask

  task automatic test_reset_mid_frame();
    int c;
    int bad;
    wq[0] = DB'($urandom);
    @(negedge sysclk_in);
    tx_data_in  = wq[0];
    data_rdy_in = 1'b1;
    c = 0;
    while (tx_serial_out !== 1'b0 && c <= BIT + 2) begin
      @(negedge sysclk_in);
      c++;
    end
    data_rdy_in = 1'b0;
    checks++; if (tx_serial_out !== 1'b0) begin errors++; $display("FAIL midrst_start: line %b, required 0", tx_serial_out); end
    // Move to the centre of data bit 3 (bit slot 4 of the frame).
    repeat (4 * BIT + BIT / 2) @(negedge sysclk_in);
    checks++; if (tx_busy_out !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b, required 1", tx_busy_out); end
    rst_in = 1'b1;
    #1;
    checks++; if (tx_serial_out !== 1'b1) begin errors++; $display("FAIL midrst_line: got %b, required 1", tx_serial_out); end
    checks++; if (tx_busy_out !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", tx_busy_out); end
    repeat (2) @(negedge sysclk_in);
    rst_in = 1'b0;
    bad = 0;
    for (int t = 0; t < FRAME + BIT; t++) begin
      @(negedge sysclk_in);
      if (tx_done_out !== 1'b0 || tx_serial_out !== 1'b1 || tx_busy_out !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_quiet: %0d active samples, required 0", bad); end
    wq[0] = DB'($urandom);
    drive_and_capture(1, 1'b1);
    checks++; if (rx_word(0) !== wq[0] || cap_timeout) begin errors++; $display("FAIL midrst_fresh: got %h, required %h", rx_word(0), wq[0]); end
    bad = 0;
    for (int t = 0; t < FRAME + BIT; t++) if (line_log[t] !== exp_line(t, 1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_wave: %0d bad samples, required 0", bad); end
  endtask

  task automatic test_boundary();
    int falls;
    int lows;
    wq[0] = 8'h00;
    wq[1] = 8'hFF;
    drive_and_capture(2, 1'b0);
    checks++; if (cap_timeout) begin errors++; $display("FAIL bnd_start: no start bit seen, required within %0d cycles", BIT + 2); end
    for (int f = 0; f < 2; f++) begin
      checks++; if (line_log[f*FRAME + BIT/2] !== 1'b0) begin errors++; $display("FAIL bnd_startbit%0d: got %b, required 0", f, line_log[f*FRAME + BIT/2]); end
      checks++; if (line_log[f*FRAME + (DB+1)*BIT + BIT/2] !== 1'b1) begin errors++; $display("FAIL bnd_stopbit%0d: got %b, required 1", f, line_log[f*FRAME + (DB+1)*BIT + BIT/2]); end
      checks++; if (rx_word(f) !== wq[f]) begin errors++; $display("FAIL bnd_word%0d: got %h, required %h", f, rx_word(f), wq[f]); end
    end
    falls = 0; lows = 0;
    for (int t = FRAME; t < 2 * FRAME + BIT; t++) begin
      if (line_log[t] === 1'b0 && line_log[t-1] === 1'b1) falls++;
      if (line_log[t] === 1'b0) lows++;
    end
    checks++; if (falls !== 1) begin errors++; $display("FAIL bnd_ff_falls: %0d, required 1", falls); end
    checks++; if (lows !== BIT) begin errors++; $display("FAIL bnd_ff_low_width: %0d, required %0d", lows, BIT); end
  endtask

  initial begin
    rst_in      = 1'b1;
    data_rdy_in = 1'b0;
    tx_data_in  = '0;
    repeat (3) @(negedge sysclk_in);
    test_reset();
    test_single_frame();
    test_data_change();
    test_stream();
    test_reset_mid_frame();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_tx.md
# uart_baud_tx

Transmit half of the UART: a baud-tick generator plus an 8N1 serializer in a single `sysclk_in` domain. Words presented on `tx_data_in` with `data_rdy_in` are sent LSB-first on `tx_serial_out`. Holding `data_rdy_in` high streams frames back-to-back. The block sits between the system bus logic and the TX pin.

## Interface
- CLK_FREQ, 100_000_000: `sysclk_in` frequency in Hz.
- BAUD_RATE, 115_200: line bit rate in bit/s.
- OVERSAMPLING, 8: number of oversample ticks per bit.
- DATA_BITS, 8: payload bits per frame.
- sysclk_in  in  1  system clock; all logic is on its rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- data_rdy_in  in  1  level-sensitive transmit request.
- tx_data_in  in  DATA_BITS  word to send; captured at the start of each frame.
- tx_serial_out  out  1  serial line; idles high.
- tx_busy_out  out  1  high while a frame is on the line.
- tx_done_out  out  1  one-cycle pulse at the end of each stop bit.
- divclk_out  out  1  one-cycle strobe per oversample period.
- baudclk_out  out  1  one-cycle strobe per bit period.

## Operation
- Clock and reset: one clock, `sysclk_in`. Reset `rst_in` is asynchronous and active-high.
- Oversample divider:
  - DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLING), integer floor. With defaults, DIV = 108.
  - Elaboration fails if DIV < 1.
  - `div_cnt` counts 0..DIV-1. `divclk_out` = 1 for the cycle in which `div_cnt` = DIV-1.
- Baud divider:
  - `os_cnt` counts divclk strobes 0..OVERSAMPLING-1.
  - `baudclk_out` = 1 in the cycle where `divclk_out` = 1 and `os_cnt` = OVERSAMPLING-1.
  - Bit period = DIV*OVERSAMPLING cycles (864 with defaults).
- The dividers free-run from reset and are not synchronised to `data_rdy_in`.
- TX FSM: states IDLE, START, DATA, STOP. All transitions occur only in cycles where `baudclk_out` = 1.
  - IDLE: line = 1, busy = 0. On a tick with `data_rdy_in` = 1:
    - latch `tx_data_in` into the shift register;
    - clear the bit counter;
    - go to START.
  - START: line = 0. On a tick, go to DATA.
  - DATA:
    - line = `shreg[0]`.
    - On each tick, shift right and increment the bit counter.
    - After DATA_BITS ticks, go to STOP.
  - STOP: line = 1. On a tick:
    - pulse `tx_done_out` high for exactly one `sysclk_in` cycle;
    - if `data_rdy_in` = 1, latch the new `tx_data_in` and go straight to START (no idle bit);
    - otherwise go to IDLE.
- `tx_busy_out` = 1 in START, DATA and STOP.
- `tx_serial_out` is driven from a register (no combinational glitches).
- `tx_data_in` is sampled only on the latching tick. Changes at any other time have no effect on the frame in flight.
- `data_rdy_in` is ignored outside IDLE and outside the STOP-exit tick.
- Reset, including mid-frame:
  - Counters go to 0; FSM goes to IDLE.
  - Outputs: `tx_serial_out` = 1; `tx_busy_out`, `tx_done_out`, `divclk_out`, `baudclk_out` = 0.
  - A partial frame is abandoned. No done pulse is produced.

## Timing
- Request to start bit: from `data_rdy_in` rising in IDLE, the start bit begins on the next baud tick. Latency is 1 to 864 cycles plus 1 register cycle.
- Frame length: exactly 10 bit periods (1 start + 8 data + 1 stop), each 864 cycles.
- Continuous mode: frame-to-frame period is 10*864 = 8640 cycles, with no gap between frames.
- Line transitions: each change of `tx_serial_out` occurs one cycle after the corresponding `baudclk_out` strobe.
- `tx_done_out` rises in the cycle after the STOP-exit tick, together with the next start bit's falling edge (if any), and stays high for 1 cycle.
- Strobe spacing:
  - `divclk_out`: every 108 cycles.
  - `baudclk_out`: every 864 cycles, coincident with every 8th `divclk_out`.

## Test plan
- Reset: assert `rst_in` mid-operation.
  - During reset: `tx_serial_out` = 1; `tx_busy_out` = `tx_done_out` = `baudclk_out` = `divclk_out` = 0.
  - After release: the first `divclk_out` occurs 108 cycles later and the first `baudclk_out` 864 cycles later.
- Single frame: `tx_data_in` = 0xA5 with a one-bit-period `data_rdy_in` pulse.
  - Line sequence: 0, 1,0,1,0,0,1,0,1, 1, each bit 864 cycles.
  - `tx_busy_out` high for 8640 cycles; one `tx_done_out` pulse; line then idles high.
- Data-change isolation: change `tx_data_in` immediately after the start-bit falling edge.
  - The frame still carries the latched word.
  - The new word goes out in the next frame.
- Continuous stream: hold `data_rdy_in` = 1 for 16 random words, updating each on its start bit.
  - All 16 words are received correctly by sampling at bit centres.
  - 16 `tx_done_out` pulses, spaced 8640 cycles apart.
  - No idle-high gap between frames.
- Reset mid-frame: assert `rst_in` during DATA bit 3.
  - Line goes high immediately; `tx_busy_out` = 0; no `tx_done_out`.
  - The next request sends a complete fresh frame.
- Boundary words: send 0x00 and 0xFF back-to-back.
  - Start bit low and stop bit high are correct in both frames.
  - 0xFF produces a single 1-bit-wide low pulse (the start bit) per frame.
